decode: RTL
===========

Name: decode

Overview:
- RV32I instruction decode stage. Sits directly downstream of the instruction-memory stage (insm) and upstream of execute.
- Consumes pc and inst over a valid/ready handshake and registers the decoded fields: register indices, sign-extended immediate, operation class, funct fields, write-enable and illegal flag.
- Honours branch flush from execute.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous reset, active-high
- valid_i  in  1  upstream has pc_i/inst_i
- ready_o  out  1  decode can accept this cycle
- pc_i  in  32  instruction address
- inst_i  in  32  instruction word
- valid_ro  out  1  decoded entry present
- ready_i  in  1  execute accepts entry
- branch_taken_i  in  1  flush: discard held and incoming entries
- pc_ro  out  32  registered pc
- inst_ro  out  32  registered raw instruction
- opclass_ro  out  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OPIMM, 8 OP, 9 FENCE, 10 SYSTEM, 15 ILLEGAL
- rs1_ro  out  5  inst[19:15]
- rs2_ro  out  5  inst[24:20]
- rd_ro  out  5  inst[11:7]
- funct3_ro  out  3  inst[14:12]
- funct7b5_ro  out  1  inst[30]
- imm_ro  out  32  sign-extended immediate
- rd_we_ro  out  1  destination write enable
- illegal_ro  out  1  illegal instruction

Behaviour:
- Reset, asynchronous, rst=1: every registered output is 0, including valid_ro, pc_ro, inst_ro, imm_ro, opclass_ro, rd_we_ro and illegal_ro. ready_o=1 once rst is released.
- Transfers:
  - Upstream transfer occurs when valid_i && ready_o.
  - Downstream transfer occurs when valid_ro && ready_i.
- Baseline ready (no skid): ready_o = !valid_ro || ready_i, combinational. Latency is 1 cycle: an accepted inst appears on the outputs at the next edge.
- Output register update, in priority order:
  1. branch_taken_i=1: valid_ro<=0 at the next edge. Any same-cycle incoming transfer is dropped. Data fields may hold their old value.
  2. Else, upstream transfer: load all fields and set valid_ro<=1.
  3. Else, downstream transfer: valid_ro<=0.
  4. Else: hold.
- Stability: while valid_ro && !ready_i, all outputs hold stable.
- Immediate formats, all sign-extended from inst[31]:
  - I: inst[31:20]; used by LOAD, OPIMM, JALR, SYSTEM.
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - FENCE and OP: imm = 0.
- Illegal detection: illegal=1 and opclass=15 when any of the following holds:
  - inst[1:0] != 2'b11;
  - opcode[6:2] is not one of the 11 RV32I opcodes;
  - inst == 32'h0000_0000 or inst == 32'hFFFF_FFFF;
  - JALR with funct3 != 0;
  - BRANCH with funct3 of 2 or 3;
  - LOAD with funct3 of 3, 6 or 7;
  - STORE with funct3 > 2.
- Write enable: rd_we = 1 for LUI, AUIPC, JAL, JALR, LOAD, OPIMM and OP, and 0 whenever rd == 0. It is 0 for BRANCH, STORE, FENCE, SYSTEM and ILLEGAL.
- Illegal entries still flow downstream with valid_ro=1. Execute raises the trap.
- Flush while stalled (valid_ro && !ready_i && branch_taken_i): the entry is dropped. No transfer is counted downstream.

Optional Feature:
- Macro: DECODE_SKID_EN.
- Defined: ready_o comes from a register, breaking the combinational ready path. A one-entry skid buffer holds the raw pc/inst accepted while the output is stalled.
  - ready_o = !skid_valid. ready_o resets to 1.
  - When the output drains, the skid entry is decoded into the output register and ready_o reasserts 1 cycle later.
  - branch_taken_i clears both the output register and the skid entry.
  - Ordering is strictly preserved.
- Undefined: combinational ready_o as specified in Behaviour; no skid storage.

Test Plan:
- Reset then valid_i=1, pc=0x0, inst=0x00500093 (addi x1,x0,5), ready_i=1 -> next cycle: valid_ro=1, opclass=7, rd=1, rs1=0, imm=0x00000005, rd_we=1, illegal=0.
- Encoding checks with ready_i=1:
  - 0x0020A423 (sw x2,8(x1)) -> opclass=6, rs1=1, rs2=2, imm=0x00000008, rd_we=0.
  - 0xFE000EE3 (beq x0,x0,-4) -> opclass=4, imm=0xFFFFFFFC.
  - 0x123452B7 (lui x5) -> opclass=0, rd=5, imm=0x12345000.
- Backpressure:
  - Stimulus: ready_i=0 for 2 cycles with valid_i=1, pc sequence 0x0, 0x4, 0x8.
  - Without skid: outputs hold pc_ro=0x0 and ready_o=0 throughout the stall, then 0x4 and 0x8 follow with no loss or duplication.
  - With DECODE_SKID_EN: 0x4 sits in the skid buffer and ready_o drops one cycle later.
- Flush:
  - Stimulus: entry pc=0x10 held with ready_i=0, then branch_taken_i=1 for 1 cycle while valid_i=1 with pc=0x14.
  - Response: next cycle valid_ro=0, and neither 0x10 nor 0x14 is ever delivered. Next accepted pc=0x28 appears normally.
- Illegal: inst=0x00000000, and separately 0x00000067 with funct3=1 (0x00001067) -> illegal=1, opclass=15, rd_we=0, valid_ro=1.
- Assert rst mid-stream with valid_ro=1 -> valid_ro=0 and all outputs 0 immediately, not waiting for a clock edge. Operation resumes correctly after rst is released.

Source files
------------

// File: rtl/decode.sv
// ---------------------------------------------------------------------------
// decode -- RV32I instruction decode stage.
//
// Takes a pc/instruction pair from the instruction-memory stage over a
// valid/ready handshake, decodes it and presents the registered result to
// execute over a second valid/ready handshake. A taken branch from execute
// flushes whatever decode holds and drops the same-cycle incoming entry.
//
// Optional feature (compile-time macro DECODE_SKID_EN):
//   defined   - ready_o is driven from state (no combinational path from
//               ready_i), backed by a one-entry skid buffer holding the raw
//               pc/inst accepted while the output register is stalled.
//   undefined - ready_o = !valid_ro || ready_i, no skid storage.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   valid_i/ready_o upstream handshake carrying pc_i / inst_i
//   valid_ro/ready_i downstream handshake for the decoded entry
//   branch_taken_i  flush request from execute
//   pc_ro, inst_ro  registered pc and raw instruction
//   opclass_ro      operation class (15 = illegal)
//   rs1_ro, rs2_ro, rd_ro, funct3_ro, funct7b5_ro  raw instruction fields
//   imm_ro          sign-extended immediate for the instruction's format
//   rd_we_ro        destination register write enable
//   illegal_ro      instruction is not a legal RV32I encoding
// ---------------------------------------------------------------------------
module decode #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    output logic            valid_ro,
    input  logic            ready_i,
    input  logic            branch_taken_i,
    output logic [XLEN-1:0] pc_ro,
    output logic [XLEN-1:0] inst_ro,
    output logic [3:0]      opclass_ro,
    output logic [4:0]      rs1_ro,
    output logic [4:0]      rs2_ro,
    output logic [4:0]      rd_ro,
    output logic [2:0]      funct3_ro,
    output logic            funct7b5_ro,
    output logic [XLEN-1:0] imm_ro,
    output logic            rd_we_ro,
    output logic            illegal_ro
);

    typedef enum logic [3:0] {
        OPC_LUI     = 4'd0,
        OPC_AUIPC   = 4'd1,
        OPC_JAL     = 4'd2,
        OPC_JALR    = 4'd3,
        OPC_BRANCH  = 4'd4,
        OPC_LOAD    = 4'd5,
        OPC_STORE   = 4'd6,
        OPC_OPIMM   = 4'd7,
        OPC_OP      = 4'd8,
        OPC_FENCE   = 4'd9,
        OPC_SYSTEM  = 4'd10,
        OPC_ILLEGAL = 4'd15
    } opclass_e;

    // inst[6:2] values of the eleven RV32I major opcodes
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_FENCE  = 5'b00011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    // Output register state
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    opclass_e        opclass_q, opclass_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic            rdWe_q, rdWe_d;
    logic            illegal_q, illegal_d;

    // Decoder input selection and results
    logic [XLEN-1:0] decPc;
    logic [XLEN-1:0] decInst;
    opclass_e        decOpclass;
    logic [XLEN-1:0] decImm;
    logic            decWritesRd;
    logic            decRdWe;
    logic            decIllegal;

    logic upXfer;
    logic loadOut;

`ifdef DECODE_SKID_EN
    logic            skidValid_q, skidValid_d;
    logic [XLEN-1:0] skidPc_q, skidPc_d;
    logic [XLEN-1:0] skidInst_q, skidInst_d;
    logic            outFree;

    // Ready depends only on skid occupancy, so it is a pure function of state
    assign ready_o = !skidValid_q;
    assign outFree = !valid_q || ready_i;

    // A parked skid entry is older than anything upstream and must go first
    assign decPc   = skidValid_q ? skidPc_q   : pc_i;
    assign decInst = skidValid_q ? skidInst_q : inst_i;
`else
    assign ready_o = !valid_q || ready_i;
    assign decPc   = pc_i;
    assign decInst = inst_i;
`endif

    assign upXfer = valid_i && ready_o;

    // Instruction decoder: classify the opcode, reject reserved funct3
    // encodings and pick the immediate format. Anything not explicitly
    // recognised falls through as illegal with a zero immediate.
    always_comb begin
        logic [4:0]      opcode;
        logic [2:0]      f3;
        logic [XLEN-1:0] immI, immS, immB, immU, immJ;

        opcode = decInst[6:2];
        f3     = decInst[14:12];
        immI   = {{20{decInst[31]}}, decInst[31:20]};
        immS   = {{20{decInst[31]}}, decInst[31:25], decInst[11:7]};
        immB   = {{19{decInst[31]}}, decInst[31], decInst[7], decInst[30:25], decInst[11:8], 1'b0};
        immU   = {decInst[31:12], 12'b0};
        immJ   = {{11{decInst[31]}}, decInst[31], decInst[19:12], decInst[20], decInst[30:21], 1'b0};

        decOpclass  = OPC_ILLEGAL;
        decImm      = '0;
        decWritesRd = 1'b0;

        // All-zero and all-one words are common symptoms of reading
        // uninitialised or missing memory, so they are never legal.
        if (decInst[1:0] == 2'b11 && decInst != '0 && decInst != '1) begin
            case (opcode)
                OP_LUI: begin
                    decOpclass  = OPC_LUI;
                    decImm      = immU;
                    decWritesRd = 1'b1;
                end
                OP_AUIPC: begin
                    decOpclass  = OPC_AUIPC;
                    decImm      = immU;
                    decWritesRd = 1'b1;
                end
                OP_JAL: begin
                    decOpclass  = OPC_JAL;
                    decImm      = immJ;
                    decWritesRd = 1'b1;
                end
                OP_JALR: begin
                    if (f3 == 3'd0) begin
                        decOpclass  = OPC_JALR;
                        decImm      = immI;
                        decWritesRd = 1'b1;
                    end
                end
                OP_BRANCH: begin
                    if (f3 != 3'd2 && f3 != 3'd3) begin
                        decOpclass = OPC_BRANCH;
                        decImm     = immB;
                    end
                end
                OP_LOAD: begin
                    if (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) begin
                        decOpclass  = OPC_LOAD;
                        decImm      = immI;
                        decWritesRd = 1'b1;
                    end
                end
                OP_STORE: begin
                    if (f3 <= 3'd2) begin
                        decOpclass = OPC_STORE;
                        decImm     = immS;
                    end
                end
                OP_OPIMM: begin
                    decOpclass  = OPC_OPIMM;
                    decImm      = immI;
                    decWritesRd = 1'b1;
                end
                OP_OP: begin
                    decOpclass  = OPC_OP;
                    decWritesRd = 1'b1;
                end
                OP_FENCE: begin
                    decOpclass = OPC_FENCE;
                end
                OP_SYSTEM: begin
                    decOpclass = OPC_SYSTEM;
                    decImm     = immI;
                end
                default: begin
                    decOpclass = OPC_ILLEGAL;
                end
            endcase
        end

        decIllegal = (decOpclass == OPC_ILLEGAL);
        // Writes to x0 are suppressed here so execute never has to check
        decRdWe    = decWritesRd && (decInst[11:7] != 5'd0);
    end

    // Next-state for the output register (and skid buffer when present).
    // A flush wins over everything; otherwise a new entry is loaded when
    // one is available, or the output empties once execute has taken it.
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        opclass_d = opclass_q;
        imm_d     = imm_q;
        rdWe_d    = rdWe_q;
        illegal_d = illegal_q;
        loadOut   = 1'b0;
`ifdef DECODE_SKID_EN
        skidValid_d = skidValid_q;
        skidPc_d    = skidPc_q;
        skidInst_d  = skidInst_q;

        if (branch_taken_i) begin
            valid_d     = 1'b0;
            skidValid_d = 1'b0;
        end else if (outFree) begin
            if (skidValid_q) begin
                loadOut     = 1'b1;
                skidValid_d = 1'b0;
            end else if (upXfer) begin
                loadOut = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end else if (upXfer) begin
            // Output is stalled but ready_o was still high: park the raw pair
            skidValid_d = 1'b1;
            skidPc_d    = pc_i;
            skidInst_d  = inst_i;
        end
`else
        if (branch_taken_i) begin
            valid_d = 1'b0;
        end else if (upXfer) begin
            loadOut = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
`endif
        if (loadOut) begin
            valid_d   = 1'b1;
            pc_d      = decPc;
            inst_d    = decInst;
            opclass_d = decOpclass;
            imm_d     = decImm;
            rdWe_d    = decRdWe;
            illegal_d = decIllegal;
        end
    end

    // State registers, cleared asynchronously so every output reads zero
    // the moment reset is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            inst_q      <= '0;
            opclass_q   <= OPC_LUI;
            imm_q       <= '0;
            rdWe_q      <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef DECODE_SKID_EN
            skidValid_q <= 1'b0;
            skidPc_q    <= '0;
            skidInst_q  <= '0;
`endif
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            opclass_q   <= opclass_d;
            imm_q       <= imm_d;
            rdWe_q      <= rdWe_d;
            illegal_q   <= illegal_d;
`ifdef DECODE_SKID_EN
            skidValid_q <= skidValid_d;
            skidPc_q    <= skidPc_d;
            skidInst_q  <= skidInst_d;
`endif
        end
    end

    // Register fields are plain slices of the registered instruction word
    assign valid_ro    = valid_q;
    assign pc_ro       = pc_q;
    assign inst_ro     = inst_q;
    assign opclass_ro  = opclass_q;
    assign rs1_ro      = inst_q[19:15];
    assign rs2_ro      = inst_q[24:20];
    assign rd_ro       = inst_q[11:7];
    assign funct3_ro   = inst_q[14:12];
    assign funct7b5_ro = inst_q[30];
    assign imm_ro      = imm_q;
    assign rd_we_ro    = rdWe_q;
    assign illegal_ro  = illegal_q;

endmodule
